// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save datapath blocks: FSM state encoding
// and the chunk-count / index-width helpers used to size the resolver.
package csa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } csa_state_e;

    function automatic int csa_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk resolver still needs a one-bit index register.
    function automatic int csa_idx_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells; the
// resolver feeds it one slice of the redundant operand per cycle.
module csa_chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
        assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/csa_resolver.sv
// Carry-propagate back end: resolves a sum/carry pair to binary, CHUNK bits
// per cycle, with valid/ready handshakes on input and output.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_cout
);

    localparam int NCHUNK = csa_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = csa_idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on state and out_ready, so a producer may wait
    // for it before raising in_valid without creating a loop.

    csa_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic [WIDTH-1:0] cry_q,   cry_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             cout_q,  cout_d;

    logic             in_fire;
    logic             last_chunk;
    int unsigned      base;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;

    assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign in_fire    = in_valid && in_ready;
    assign last_chunk = (idx_q == LAST_IDX);
    assign out_valid  = (state_q == ST_DONE);
    assign out_value  = value_q;
    assign out_cout   = cout_q;

    always_comb begin
        base    = int'(idx_q) * CHUNK;
        chunk_a = sum_q[base +: CHUNK];
        chunk_b = cry_q[base +: CHUNK];
    end

    csa_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cry_d   = cry_q;
        value_d = value_q;
        cout_d  = cout_q;

        case (state_q)
            ST_BUSY: begin
                value_d[base +: CHUNK] = chunk_sum;
                carry_d                = chunk_cout;
                idx_d                  = idx_q + 1'b1;
                if (last_chunk) begin
                    cout_d  = chunk_cout;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept overrides the DONE->IDLE path so results can stream back to back.
        if (in_fire) begin
            sum_d   = in_sum;
            cry_d   = in_carry;
            carry_d = 1'b0;
            idx_d   = '0;
            cout_d  = 1'b0;
            state_d = ST_BUSY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cry_q   <= '0;
            value_q <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cry_q   <= cry_d;
            value_q <= value_d;
            cout_q  <= cout_d;
        end
    end

endmodule

// File: tb/tb_csa_resolver.sv
// Directed and randomized checks of csa_resolver against an arithmetic model
// of (sum + carry) with exact latency and handshake expectations.
module tb_csa_resolver;

    localparam int WIDTH  = 8;
    localparam int CHUNK  = 2;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic             out_cout;

    int n_cmp;
    int n_err;

    logic [WIDTH:0] exp_q[$];

    csa_resolver #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_cout  (out_cout)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: full-precision unsigned sum, top bit is the carry out.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        int unsigned total;
        total = int'(s) + int'(c);
        return (WIDTH+1)'(total);
    endfunction

    // One full operation from IDLE: accept, exact-latency check, optional stall, drain.
    task automatic run_op(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c, input int stall);
        logic [WIDTH:0] exp;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        in_sum    = s;
        in_carry  = c;
        tick();
        in_valid  = 1'b0;
        in_sum    = $urandom;
        in_carry  = $urandom;
        exp_q.push_back(model(s, c));
        for (int i = 1; i < NCHUNK; i++) begin
            tick();
            check("busy_out_valid", 32'(out_valid), 32'd0);
        end
        tick();
        check("latency_out_valid", 32'(out_valid), 32'd1);
        exp = exp_q.pop_front();
        check("out_value", 32'(out_value), 32'(exp[WIDTH-1:0]));
        check("out_cout", 32'(out_cout), 32'(exp[WIDTH]));
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_value", 32'(out_value), 32'(exp[WIDTH-1:0]));
            check("stall_cout", 32'(out_cout), 32'(exp[WIDTH]));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] rs;
        logic [WIDTH-1:0] rc;

        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        #2 rst = 1'b0;
        tick();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_value", 32'(out_value), 32'd0);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic, full ripple, overflow, cleared carry between ops
        run_op(8'h0F, 8'h01, 0);
        check("one_cycle_valid", 32'(out_valid), 32'd0);
        run_op(8'hFF, 8'h01, 0);
        run_op(8'hFF, 8'hFF, 0);
        run_op(8'hA5, 8'h5A, 0);
        run_op(8'h00, 8'h00, 0);

        // Back-to-back with in_valid held
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sum    = 8'h10;
        in_carry  = 8'h20;
        tick();
        in_sum    = 8'h33;
        in_carry  = 8'h44;
        for (int i = 1; i < NCHUNK; i++) begin
            tick();
            check("b2b_busy1_valid", 32'(out_valid), 32'd0);
            check("b2b_busy1_in_ready", 32'(in_ready), 32'd0);
        end
        tick();
        check("b2b_first_valid", 32'(out_valid), 32'd1);
        check("b2b_first_value", 32'(out_value), 32'h30);
        check("b2b_first_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b_gap_valid", 32'(out_valid), 32'd0);
        for (int i = 1; i < NCHUNK; i++) begin
            tick();
            check("b2b_busy2_valid", 32'(out_valid), 32'd0);
        end
        tick();
        check("b2b_second_valid", 32'(out_valid), 32'd1);
        check("b2b_second_value", 32'(out_value), 32'h77);
        check("b2b_second_cout", 32'(out_cout), 32'd0);
        tick();
        check("b2b_drain_valid", 32'(out_valid), 32'd0);

        // Backpressure for 6 cycles, then exactly one transfer
        run_op(8'hC3, 8'h7E, 6);
        tick();
        check("bp_no_second_valid", 32'(out_valid), 32'd0);
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of BUSY at chunk index 2
        in_valid  = 1'b1;
        in_sum    = 8'hFF;
        in_carry  = 8'hFF;
        tick();
        in_valid  = 1'b0;
        tick();
        tick();
        check("pre_rst_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_value", 32'(out_value), 32'd0);
        check("async_rst_cout", 32'(out_cout), 32'd0);
        tick();
        #2 rst = 1'b0;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);
        run_op(8'h7F, 8'h01, 0);

        // Randomized operands and stalls
        for (int n = 0; n < 40; n++) begin
            rs = WIDTH'($urandom);
            rc = WIDTH'($urandom);
            run_op(rs, rc, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) tick();
        end

        exp = model(8'hFF, 8'hFF);
        check("model_sanity_overflow", 32'(exp), 32'h1FE);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
